// File: rtl/sel_reg_arbiter_if.sv
// Register-select bus between the per-operation sequencers and the arbiter.
// The sequencers own req/sel_in/done; the arbiter drives grant, select and status.
interface sel_reg_arbiter_if #(
    parameter int N_CH = 2,
    parameter int W    = 4
);
    logic [N_CH-1:0]   req;
    logic [N_CH*W-1:0] sel_in;
    logic [N_CH-1:0]   done;
    logic [N_CH-1:0]   gnt;
    logic [W-1:0]      sel_reg;
    logic              busy;
    logic              timeout;

    modport master (
        output req, sel_in, done,
        input  gnt, sel_reg, busy, timeout
    );

    modport slave (
        input  req, sel_in, done,
        output gnt, sel_reg, busy, timeout
    );
endinterface

// File: rtl/sel_reg_arbiter.sv
// Round-robin arbiter for the shared register-select bus: registered one-hot grant,
// select held stable for the whole grant, done/watchdog release, one turnaround cycle.
module sel_reg_arbiter #(
    parameter int N_CH    = 2,
    parameter int W       = 4,
    parameter int TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           reset,
    sel_reg_arbiter_if.slave bus
);
    localparam int PW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [PW-1:0] LAST_CH  = PW'(N_CH - 1);
    localparam logic [PW:0]   N_CH_W   = (PW + 1)'(N_CH);

    typedef enum logic [1:0] {IDLE, GRANT, REL} state_t;

    state_t          state_q, state_d;
    logic [N_CH-1:0] gnt_q, gnt_d;
    logic [W-1:0]    sel_q, sel_d;
    logic            busy_q, busy_d;
    logic            tmo_q, tmo_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [W-1:0]    sel_arr [N_CH];
    logic            found;
    logic [PW-1:0]   pick;
    logic [PW:0]     cand;

    for (genvar g = 0; g < N_CH; g++) begin : g_unpack
        assign sel_arr[g] = bus.sel_in[g*W +: W];
    end

    // First requester at or after ptr, wrapping modulo N_CH.
    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        cand  = '0;
        for (int k = 0; k < N_CH; k++) begin
            cand = {1'b0, ptr_q} + (PW + 1)'(k);
            if (cand >= N_CH_W) begin
                cand = cand - N_CH_W;
            end
            if (!found && bus.req[cand[PW-1:0]]) begin
                found = 1'b1;
                pick  = cand[PW-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        busy_d  = busy_q;
        tmo_d   = 1'b0;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                gnt_d  = '0;
                busy_d = 1'b0;
                if (found) begin
                    gnt_d[pick] = 1'b1;
                    sel_d       = sel_arr[pick];
                    busy_d      = 1'b1;
                    cnt_d       = '0;
                    owner_d     = pick;
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
                // done wins over a coincident terminal count, so no pulse in that case.
                if (bus.done[owner_q] || ((TIMEOUT != 0) && (cnt_q == CNT_LAST))) begin
                    gnt_d   = '0;
                    ptr_d   = (owner_q == LAST_CH) ? '0 : owner_q + 1'b1;
                    tmo_d   = !bus.done[owner_q];
                    state_d = REL;
                end
            end
            REL: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                gnt_d   = '0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            busy_q  <= 1'b0;
            tmo_q   <= 1'b0;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            tmo_q   <= tmo_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.sel_reg = sel_q;
    assign bus.busy    = busy_q;
    assign bus.timeout = tmo_q;
endmodule

// File: tb/tb_sel_reg_arbiter.sv
// Directed bench for sel_reg_arbiter: three instances (TIMEOUT 255, 4, 0) share one
// stimulus stream; expected outputs are queued per step and popped after each edge.
module tb_sel_reg_arbiter;
    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] req;
    logic [1:0] done;
    logic [7:0] sel_in;

    always #5 clk = ~clk;

    sel_reg_arbiter_if #(.N_CH(2), .W(4)) if_a ();
    sel_reg_arbiter_if #(.N_CH(2), .W(4)) if_b ();
    sel_reg_arbiter_if #(.N_CH(2), .W(4)) if_c ();

    assign if_a.req = req;  assign if_a.sel_in = sel_in;  assign if_a.done = done;
    assign if_b.req = req;  assign if_b.sel_in = sel_in;  assign if_b.done = done;
    assign if_c.req = req;  assign if_c.sel_in = sel_in;  assign if_c.done = done;

    sel_reg_arbiter #(.N_CH(2), .W(4), .TIMEOUT(255)) dut_a (.clk(clk), .reset(reset), .bus(if_a));
    sel_reg_arbiter #(.N_CH(2), .W(4), .TIMEOUT(4))   dut_b (.clk(clk), .reset(reset), .bus(if_b));
    sel_reg_arbiter #(.N_CH(2), .W(4), .TIMEOUT(0))   dut_c (.clk(clk), .reset(reset), .bus(if_c));

    typedef struct {
        string      tag;
        int         dut;
        logic [7:0] exp;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [7:0] observe(int d);
        case (d)
            0:       return {if_a.gnt, if_a.sel_reg, if_a.busy, if_a.timeout};
            1:       return {if_b.gnt, if_b.sel_reg, if_b.busy, if_b.timeout};
            default: return {if_c.gnt, if_c.sel_reg, if_c.busy, if_c.timeout};
        endcase
    endfunction

    task automatic expect_out(input string tag, input int d, input logic [1:0] g,
                              input logic [3:0] s, input logic b, input logic t);
        exp_t e;
        e.tag = tag;
        e.dut = d;
        e.exp = {g, s, b, t};
        sbq.push_back(e);
    endtask

    task automatic tick_check();
        exp_t       e;
        logic [7:0] obs;
        @(posedge clk);
        #1;
        while (sbq.size() > 0) begin
            e   = sbq.pop_front();
            obs = observe(e.dut);
            n_checks++;
            assert (obs === e.exp) else begin
                n_fail++;
                $error("FAIL %s dut%0d: got gnt=%b sel=%h busy=%b tmo=%b, want gnt=%b sel=%h busy=%b tmo=%b",
                       e.tag, e.dut, obs[7:6], obs[5:2], obs[1], obs[0],
                       e.exp[7:6], e.exp[5:2], e.exp[1], e.exp[0]);
            end
        end
    endtask

    initial begin
        logic [1:0] ch_oh;
        logic [3:0] ch_sel;

        reset  = 1'b1;
        req    = 2'b00;
        done   = 2'b00;
        sel_in = 8'hA5;
        expect_out("reset_a", 0, 2'b00, 4'h0, 1'b0, 1'b0);
        expect_out("reset_b", 1, 2'b00, 4'h0, 1'b0, 1'b0);
        expect_out("reset_c", 2, 2'b00, 4'h0, 1'b0, 1'b0);
        tick_check();
        reset = 1'b0;

        // Single request, select held against sel_in changes and req drop.
        req = 2'b01;
        expect_out("single_grant", 0, 2'b01, 4'h5, 1'b1, 1'b0);
        tick_check();
        sel_in = 8'hFF;
        req    = 2'b00;
        expect_out("single_hold", 0, 2'b01, 4'h5, 1'b1, 1'b0);
        tick_check();
        sel_in = 8'hA5;
        done   = 2'b01;
        expect_out("single_rel", 0, 2'b00, 4'h5, 1'b1, 1'b0);
        tick_check();
        done = 2'b00;
        expect_out("single_idle", 0, 2'b00, 4'h5, 1'b0, 1'b0);
        tick_check();

        // Round robin with both requesting; ch0 was last released so ch1 goes first.
        req   = 2'b11;
        ch_oh = 2'b10;
        for (int i = 0; i < 4; i++) begin
            ch_sel = (ch_oh == 2'b01) ? 4'h5 : 4'hA;
            expect_out("rr_grant", 0, ch_oh, ch_sel, 1'b1, 1'b0);
            tick_check();
            done = ch_oh;
            expect_out("rr_rel", 0, 2'b00, ch_sel, 1'b1, 1'b0);
            tick_check();
            done = 2'b00;
            expect_out("rr_idle", 0, 2'b00, ch_sel, 1'b0, 1'b0);
            tick_check();
            ch_oh = ~ch_oh;
        end

        // Non-owner done and owner req drop are ignored.
        req = 2'b01;
        expect_out("nonown_grant", 0, 2'b01, 4'h5, 1'b1, 1'b0);
        tick_check();
        req  = 2'b00;
        done = 2'b10;
        expect_out("nonown_hold1", 0, 2'b01, 4'h5, 1'b1, 1'b0);
        tick_check();
        expect_out("nonown_hold2", 0, 2'b01, 4'h5, 1'b1, 1'b0);
        tick_check();
        done = 2'b01;
        expect_out("nonown_rel", 0, 2'b00, 4'h5, 1'b1, 1'b0);
        tick_check();
        done = 2'b00;
        expect_out("nonown_idle", 0, 2'b00, 4'h5, 1'b0, 1'b0);
        tick_check();

        // Watchdog on TIMEOUT=4: ch1 never signals done, ch0 waiting.
        reset = 1'b1;
        expect_out("wd_reset", 1, 2'b00, 4'h0, 1'b0, 1'b0);
        tick_check();
        reset = 1'b0;
        req   = 2'b10;
        expect_out("wd_grant", 1, 2'b10, 4'hA, 1'b1, 1'b0);
        tick_check();
        req = 2'b11;
        for (int i = 0; i < 3; i++) begin
            expect_out("wd_hold", 1, 2'b10, 4'hA, 1'b1, 1'b0);
            tick_check();
        end
        expect_out("wd_release", 1, 2'b00, 4'hA, 1'b1, 1'b1);
        expect_out("wd_long_hold", 0, 2'b10, 4'hA, 1'b1, 1'b0);
        tick_check();
        expect_out("wd_idle", 1, 2'b00, 4'hA, 1'b0, 1'b0);
        tick_check();
        expect_out("wd_regrant", 1, 2'b01, 4'h5, 1'b1, 1'b0);
        tick_check();
        done = 2'b01;
        expect_out("wd_done", 1, 2'b00, 4'h5, 1'b1, 1'b0);
        tick_check();
        done = 2'b00;
        req  = 2'b00;
        expect_out("wd_done_idle", 1, 2'b00, 4'h5, 1'b0, 1'b0);
        tick_check();

        // done coincident with the terminal count releases without a pulse.
        req = 2'b10;
        expect_out("tc_grant", 1, 2'b10, 4'hA, 1'b1, 1'b0);
        tick_check();
        for (int i = 0; i < 3; i++) begin
            expect_out("tc_hold", 1, 2'b10, 4'hA, 1'b1, 1'b0);
            tick_check();
        end
        done = 2'b10;
        expect_out("tc_release", 1, 2'b00, 4'hA, 1'b1, 1'b0);
        tick_check();
        done = 2'b00;
        req  = 2'b00;
        expect_out("tc_idle", 1, 2'b00, 4'hA, 1'b0, 1'b0);
        tick_check();

        // TIMEOUT=0: a long grant is never force-released.
        reset = 1'b1;
        expect_out("nowd_reset", 2, 2'b00, 4'h0, 1'b0, 1'b0);
        tick_check();
        reset = 1'b0;
        req   = 2'b01;
        expect_out("nowd_grant", 2, 2'b01, 4'h5, 1'b1, 1'b0);
        tick_check();
        req = 2'b00;
        for (int i = 0; i < 1000; i++) begin
            if (i % 100 == 99) begin
                expect_out("nowd_hold", 2, 2'b01, 4'h5, 1'b1, 1'b0);
            end
            tick_check();
        end
        done = 2'b01;
        expect_out("nowd_rel", 2, 2'b00, 4'h5, 1'b1, 1'b0);
        tick_check();
        done = 2'b00;
        expect_out("nowd_idle", 2, 2'b00, 4'h5, 1'b0, 1'b0);
        tick_check();

        // Reset in the middle of a grant; ptr returns to 0.
        reset = 1'b1;
        tick_check();
        reset = 1'b0;
        req   = 2'b10;
        expect_out("midrst_grant", 0, 2'b10, 4'hA, 1'b1, 1'b0);
        tick_check();
        reset = 1'b1;
        req   = 2'b00;
        expect_out("midrst_reset", 0, 2'b00, 4'h0, 1'b0, 1'b0);
        tick_check();
        reset = 1'b0;
        req   = 2'b01;
        expect_out("midrst_regrant", 0, 2'b01, 4'h5, 1'b1, 1'b0);
        tick_check();
        req = 2'b00;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
